// File: rtl/ldpc_job_sched.sv
// Two-requester round-robin job scheduler for an LDPC encode/decode core.
// Latches job parameters at grant, watches the core with a watchdog, reports done/timeout.
module ldpc_job_sched #(
    parameter int TIMEOUT_W = 16,
    parameter int ITER_W    = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic [1:0]           req_i,
    input  logic [1:0]           mode_i,
    input  logic [ITER_W-1:0]    cfg_iter_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic [1:0]           gnt_o,
    output logic [1:0]           done_o,
    output logic [1:0]           err_o,
    output logic                 core_start_o,
    output logic                 core_mode_o,
    output logic [ITER_W-1:0]    core_iter_o,
    input  logic                 core_done_i,
    output logic                 irq_o,
    input  logic                 irq_clr_i
);

    typedef enum logic [2:0] {IDLE, GRANT, START, RUN, FIN} state_t;

    state_t               state, state_nxt;
    logic [1:0]           gnt;
    logic                 prio;
    logic                 win;
    logic                 ok;
    logic                 timed_out;
    logic                 mode_q;
    logic [ITER_W-1:0]    iter_q;
    logic [TIMEOUT_W-1:0] wd;
    logic                 irq;
    logic                 start;
    logic [1:0]           done;
    logic [1:0]           err;

    // prio names the requester favoured on a tie (the one not granted last)
    always_comb begin
        if (req_i == 2'b11) win = prio;
        else                win = req_i[1];
    end

    assign timed_out = (timeout_i != '0) && (wd == timeout_i);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done      = 2'b00;
        err       = 2'b00;
        case (state)
            IDLE:  if (|req_i) state_nxt = GRANT;
            GRANT: state_nxt = START;
            START: begin
                start     = 1'b1;
                state_nxt = RUN;
            end
            RUN:   if (core_done_i || timed_out) state_nxt = FIN;
            FIN: begin
                if (ok) done = gnt;
                else    err  = gnt;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ok is rewritten every RUN cycle, so it holds the exit reason in FIN; done beats timeout
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            gnt    <= 2'b00;
            prio   <= 1'b0;
            ok     <= 1'b0;
            mode_q <= 1'b0;
            iter_q <= '0;
            wd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        gnt    <= win ? 2'b10 : 2'b01;
                        mode_q <= mode_i[win];
                        iter_q <= cfg_iter_i;
                    end
                end
                START: wd <= '0;
                RUN: begin
                    if (wd != '1) wd <= wd + 1'b1;
                    ok <= core_done_i;
                end
                FIN: begin
                    gnt  <= 2'b00;
                    prio <= ~gnt[1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni)             irq <= 1'b0;
        else if ((|done) || (|err)) irq <= 1'b1;
        else if (irq_clr_i)         irq <= 1'b0;
    end

    assign gnt_o        = gnt;
    assign done_o       = done;
    assign err_o        = err;
    assign core_start_o = start;
    assign core_mode_o  = mode_q;
    assign core_iter_o  = iter_q;
    assign irq_o        = irq;

endmodule

// File: tb/tb_ldpc_job_sched.sv
// Scoreboard bench for ldpc_job_sched: directed jobs push expected start/finish events,
// a negedge monitor pops and compares them whenever the DUT pulses.
module tb_ldpc_job_sched;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  mode;
    logic [3:0]  cfg_iter;
    logic [15:0] timeout;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        core_start;
    logic        core_mode;
    logic [3:0]  core_iter;
    logic        core_done;
    logic        irq;
    logic        irq_clr;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] g;
        logic       m;
        logic [3:0] it;
    } start_t;

    typedef struct packed {
        logic [1:0] g;
        logic [1:0] d;
        logic [1:0] e;
    } fin_t;

    start_t start_q[$];
    fin_t   fin_q[$];

    ldpc_job_sched #(.TIMEOUT_W(16), .ITER_W(4)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .req_i        (req),
        .mode_i       (mode),
        .cfg_iter_i   (cfg_iter),
        .timeout_i    (timeout),
        .gnt_o        (gnt),
        .done_o       (done),
        .err_o        (err),
        .core_start_o (core_start),
        .core_mode_o  (core_mode),
        .core_iter_o  (core_iter),
        .core_done_i  (core_done),
        .irq_o        (irq),
        .irq_clr_i    (irq_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: every start or finish pulse must match the oldest expectation
    always @(negedge clk) begin
        if (core_start) begin
            if (start_q.size() == 0) begin
                chk("unexpected_start", 32'(core_start), 32'h0);
            end else begin
                start_t s;
                s = start_q.pop_front();
                chk("start_gnt", 32'(gnt), 32'(s.g));
                chk("start_mode", 32'(core_mode), 32'(s.m));
                chk("start_iter", 32'(core_iter), 32'(s.it));
            end
        end
        if ((done != 2'b00) || (err != 2'b00)) begin
            if (fin_q.size() == 0) begin
                chk("unexpected_fin", {28'h0, done, err}, 32'h0);
            end else begin
                fin_t f;
                f = fin_q.pop_front();
                chk("fin_gnt", 32'(gnt), 32'(f.g));
                chk("fin_done", 32'(done), 32'(f.d));
                chk("fin_err", 32'(err), 32'(f.e));
            end
        end
    end

    // One job; cycle 0 is the current cycle. done_cyc/clr_cyc < 0 means never.
    task automatic job(input logic [1:0] r, input logic [1:0] m, input logic [3:0] it,
                       input int done_cyc, input int clr_cyc, input logic [1:0] exp_g,
                       input bit exp_to, input bit hold, input int exp_end);
        start_t s;
        fin_t   f;
        int     c;
        req      = r;
        mode     = m;
        cfg_iter = it;
        s.g  = exp_g;
        s.m  = m[exp_g[1]];
        s.it = it;
        start_q.push_back(s);
        f.g = exp_g;
        f.d = exp_to ? 2'b00 : exp_g;
        f.e = exp_to ? exp_g : 2'b00;
        fin_q.push_back(f);
        tick();
        chk("grant", 32'(gnt), 32'(exp_g));
        chk("no_early_start", 32'(core_start), 32'h0);
        tick();
        chk("start_latency", 32'(core_start), 32'h1);
        if (!hold) req = 2'b00;
        mode     = ~m;
        cfg_iter = ~it;
        c = 2;
        while (gnt != 2'b00 && c < 60) begin
            core_done = (c == done_cyc);
            irq_clr   = (c == clr_cyc);
            tick();
            c++;
        end
        core_done = 1'b0;
        irq_clr   = 1'b0;
        chk("job_end_cycle", 32'(c), 32'(exp_end));
        chk("irq_after_job", 32'(irq), 32'h1);
    endtask

    task automatic clear_irq();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("irq_cleared", 32'(irq), 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_start", 32'(core_start), 32'h0);
        chk("rst_done_err", {28'h0, done, err}, 32'h0);
        chk("rst_mode", 32'(core_mode), 32'h0);
        chk("rst_iter", 32'(core_iter), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        start_t s;
        rst_n = 1'b0; req = 2'b00; mode = 2'b00; cfg_iter = 4'h0;
        timeout = 16'd0; core_done = 1'b0; irq_clr = 1'b0;
        do_reset();

        // single encode job, watchdog disabled, done at cycle 10
        job(2'b01, 2'b00, 4'd3, 10, -1, 2'b01, 1'b0, 1'b0, 12);
        clear_irq();

        // contention from reset: 01, 10, 01 with requester 1 asking for decode
        do_reset();
        job(2'b11, 2'b10, 4'd5, 5, -1, 2'b01, 1'b0, 1'b1, 7);
        job(2'b11, 2'b10, 4'd6, 4, -1, 2'b10, 1'b0, 1'b1, 6);
        job(2'b11, 2'b10, 4'd7, 6, -1, 2'b01, 1'b0, 1'b1, 8);
        req = 2'b00;
        clear_irq();

        // watchdog expiry: RUN from cycle 3, count hits 5 at cycle 8
        timeout = 16'd5;
        job(2'b10, 2'b10, 4'd9, -1, -1, 2'b10, 1'b1, 1'b0, 10);
        chk("timeout_idle_start", 32'(core_start), 32'h0);
        clear_irq();

        // done on the expiry cycle wins; clear coincides with the done pulse
        job(2'b01, 2'b01, 4'd2, 8, 9, 2'b01, 1'b0, 1'b0, 10);

        // reset during RUN: job abandoned, tie then goes to requester 0
        req = 2'b10; mode = 2'b00; cfg_iter = 4'd4;
        s.g = 2'b10; s.m = 1'b0; s.it = 4'd4;
        start_q.push_back(s);
        tick();
        tick();
        req = 2'b00;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrun_gnt", 32'(gnt), 32'h0);
        chk("midrun_done_err", {28'h0, done, err}, 32'h0);
        chk("midrun_mode_iter", {27'h0, core_mode, core_iter}, 32'h0);
        chk("midrun_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        job(2'b11, 2'b00, 4'd1, 5, -1, 2'b01, 1'b0, 1'b0, 7);

        // stray core_done in IDLE must not start or finish anything
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        tick();
        chk("stray_done_gnt", 32'(gnt), 32'h0);
        chk("start_q_empty", 32'(start_q.size()), 32'h0);
        chk("fin_q_empty", 32'(fin_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
